// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a fetch read port and a load/store port share one
// synchronous single-port memory, with round-robin or fixed-priority arbitration.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int RR = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [3:0]    ls_be_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [31:0]   ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [31:0]   ls_rdata_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-3:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {NONE, IF_PEND, LS_PEND} owner_e;

  owner_e state_reg;
  logic   last_ls_reg;
  logic   ls_wins;
  logic   unused_addr_lsbs;

  // Byte offsets are dropped on purpose; accesses are always word-aligned.
  assign unused_addr_lsbs = ^{if_addr_i[1:0], ls_addr_i[1:0]};

  // Tie-break: LS takes a tie unless it was the most recent winner under round-robin.
  assign ls_wins  = (RR != 0) ? ~last_ls_reg : 1'b1;
  assign if_gnt_o = ~rst_i & if_req_i & ~(ls_req_i & ls_wins);
  assign ls_gnt_o = ~rst_i & ls_req_i & ~(if_req_i & ~ls_wins);

  assign mem_en_o    = if_gnt_o | ls_gnt_o;
  assign mem_we_o    = (ls_gnt_o & ls_we_i) ? ls_be_i : 4'b0000;
  assign mem_wdata_o = (mem_we_o != 4'b0000) ? ls_wdata_i : 32'h0;
  assign mem_addr_o  = ls_gnt_o ? ls_addr_i[AW-1:2] :
                       if_gnt_o ? if_addr_i[AW-1:2] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= NONE;
      last_ls_reg <= 1'b1;
    end else begin
      if (if_gnt_o)
        state_reg <= IF_PEND;
      else if (ls_gnt_o && !ls_we_i)
        state_reg <= LS_PEND;
      else
        state_reg <= NONE;
      if (if_gnt_o || ls_gnt_o)
        last_ls_reg <= ls_gnt_o;
    end
  end

  // Read data returns one cycle after the grant; a reset in that cycle squashes it.
  assign if_rvalid_o = ~rst_i & (state_reg == IF_PEND);
  assign ls_rvalid_o = ~rst_i & (state_reg == LS_PEND);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance with a memory model and scoreboard,
// plus a fixed-priority instance whose grants are checked on the same stimulus.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [3:0]  ls_be_i = '0;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic [31:0] mem_rdata_i = '0;

  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_en_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [29:0] mem_addr_o;

  logic        fp_if_gnt, fp_if_rvalid, fp_ls_gnt, fp_ls_rvalid, fp_mem_en;
  logic [31:0] fp_if_rdata, fp_ls_rdata, fp_mem_wdata;
  logic [3:0]  fp_mem_we;
  logic [29:0] fp_mem_addr;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.AW(32), .RR(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  mem_arbiter #(.AW(32), .RR(0)) u_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(fp_if_gnt),
    .if_rvalid_o(fp_if_rvalid), .if_rdata_o(fp_if_rdata),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(fp_ls_gnt), .ls_rvalid_o(fp_ls_rvalid),
    .ls_rdata_o(fp_ls_rdata), .mem_en_o(fp_mem_en), .mem_we_o(fp_mem_we),
    .mem_addr_o(fp_mem_addr), .mem_wdata_o(fp_mem_wdata), .mem_rdata_i(32'h0)
  );

  // Synchronous memory behind the round-robin instance
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o == 4'b0000)
        mem_rdata_i <= mem[mem_addr_o[7:0]];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) mem[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] sb_q[$];   // {kind, data}: kind 1 = IF read, 2 = LS read, 0 = nothing
  logic last_ls_m = 1'b1;
  logic e_if, e_ls;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic eval_cycle();
    logic [33:0] prev;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_we;
    logic [7:0]  idx;
    prev = '0;
    if (sb_q.size() > 0) prev = sb_q.pop_front();
    if (rst_i) prev = '0;
    check_eq("if_rvalid", if_rvalid_o, prev[33:32] == 2'd1);
    check_eq("ls_rvalid", ls_rvalid_o, prev[33:32] == 2'd2);
    check_eq("if_rdata", if_rdata_o, (prev[33:32] == 2'd1) ? prev[31:0] : 32'h0);
    check_eq("ls_rdata", ls_rdata_o, (prev[33:32] == 2'd2) ? prev[31:0] : 32'h0);

    if (rst_i) begin
      e_if = 1'b0; e_ls = 1'b0;
    end else if (if_req_i && ls_req_i) begin
      e_ls = ~last_ls_m; e_if = last_ls_m;
    end else begin
      e_if = if_req_i; e_ls = ls_req_i;
    end
    e_we   = (e_ls && ls_we_i) ? ls_be_i : 4'b0000;
    e_wd   = (e_we != 4'b0000) ? ls_wdata_i : 32'h0;
    e_addr = e_ls ? {2'b00, ls_addr_i[31:2]} : e_if ? {2'b00, if_addr_i[31:2]} : 32'h0;
    check_eq("if_gnt", if_gnt_o, e_if);
    check_eq("ls_gnt", ls_gnt_o, e_ls);
    check_eq("mem_en", mem_en_o, e_if | e_ls);
    check_eq("mem_addr", mem_addr_o, e_addr);
    check_eq("mem_we", mem_we_o, e_we);
    check_eq("mem_wdata", mem_wdata_o, e_wd);
    check_eq("fp_if_gnt", fp_if_gnt, !rst_i && if_req_i && !ls_req_i);
    check_eq("fp_ls_gnt", fp_ls_gnt, !rst_i && ls_req_i);

    idx = e_addr[7:0];
    if (e_if) begin
      sb_q.push_back({2'd1, ref_mem[idx]});
      $display("txn IF read  word=0x%0h", idx);
    end else if (e_ls && !ls_we_i) begin
      sb_q.push_back({2'd2, ref_mem[idx]});
      $display("txn LS load  word=0x%0h", idx);
    end else begin
      if (e_ls) begin
        for (int b = 0; b < 4; b++)
          if (ls_be_i[b]) ref_mem[idx][8*b +: 8] = ls_wdata_i[8*b +: 8];
        $display("txn LS store word=0x%0h be=%b data=0x%0h", idx, ls_be_i, ls_wdata_i);
      end
      sb_q.push_back(34'h0);
    end
    if (rst_i) last_ls_m = 1'b1;
    else if (e_if || e_ls) last_ls_m = e_ls;
  endtask

  task automatic step(input logic r, input logic ir, input logic [9:0] ia, input logic lr,
                      input logic we, input logic [3:0] be, input logic [9:0] la,
                      input logic [31:0] wd);
    @(posedge clk_i);
    #1;
    rst_i = r; if_req_i = ir; if_addr_i = {22'h0, ia};
    ls_req_i = lr; ls_we_i = we; ls_be_i = be; ls_addr_i = {22'h0, la}; ls_wdata_i = wd;
    @(negedge clk_i);
    eval_cycle();
  endtask

  initial begin
    logic ir, lr, we;
    logic [9:0] ia, la;
    logic [3:0] be;
    logic [31:0] wd;
    for (int i = 0; i < 256; i++) begin
      mem[i] = i * 32'h9E37_79B1;
      ref_mem[i] = i * 32'h9E37_79B1;
    end
    mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Both requesting right after reset: IF, LS, IF, LS
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 10'h014, 1, 0, 4'hF, 10'h020, 0);
      check_eq("rr_seq_if", if_gnt_o, (i % 2) == 0);
      check_eq("fp_seq_ls", fp_ls_gnt, 1'b1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Single fetch of word 4
    step(0, 1, 10'h010, 0, 0, 0, 0, 0);
    check_eq("if_word4_addr", mem_addr_o, 30'd4);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("if_word4_data", if_rdata_o, 32'hDEAD_BEEF);
    // Misaligned byte store, then fetch the merged word
    step(0, 0, 0, 1, 1, 4'b0010, 10'h023, 32'h0000_AB00);
    check_eq("st_addr", mem_addr_o, 30'd8);
    check_eq("st_we", mem_we_o, 4'b0010);
    step(0, 1, 10'h020, 0, 0, 0, 0, 0);
    check_eq("st_no_rvalid", ls_rvalid_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Load squashed by reset, then fetch accepted immediately after reset
    step(0, 0, 0, 1, 0, 4'hF, 10'h030, 0);
    step(1, 1, 10'h040, 0, 0, 0, 0, 0);
    check_eq("rst_ls_rvalid", ls_rvalid_o, 1'b0);
    step(0, 1, 10'h040, 0, 0, 0, 0, 0);
    check_eq("post_rst_gnt", if_gnt_o, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic honouring the hold-until-granted protocol, with occasional drops
    ir = 0; lr = 0; we = 0; ia = 0; la = 0; be = 0; wd = 0;
    for (int n = 0; n < 300; n++) begin
      if (!ir || e_if) begin
        ir = 1'($urandom_range(0, 1)); ia = 10'($urandom);
      end else if ($urandom_range(0, 9) == 0) ir = 0;
      if (!lr || e_ls) begin
        lr = 1'($urandom_range(0, 1)); la = 10'($urandom);
        we = 1'($urandom_range(0, 1)); be = 4'($urandom); wd = $urandom;
      end else if ($urandom_range(0, 9) == 0) lr = 0;
      step(0, ir, ia, lr, we, be, la, wd);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
